// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter: M0 (IFU) and M1 (LSU) share one memory slave, one transaction at a time.
// Only grant/FSM state is registered; all channels pass through combinationally once granted.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    // master 0
    input  logic [ADDR_W-1:0]   i_m0_araddr,
    input  logic                i_m0_arvalid,
    output logic                o_m0_arready,
    output logic [DATA_W-1:0]   o_m0_rdata,
    output logic [1:0]          o_m0_rresp,
    output logic                o_m0_rvalid,
    input  logic                i_m0_rready,
    input  logic [ADDR_W-1:0]   i_m0_awaddr,
    input  logic                i_m0_awvalid,
    output logic                o_m0_awready,
    input  logic [DATA_W-1:0]   i_m0_wdata,
    input  logic [DATA_W/8-1:0] i_m0_wstrb,
    input  logic                i_m0_wvalid,
    output logic                o_m0_wready,
    output logic [1:0]          o_m0_bresp,
    output logic                o_m0_bvalid,
    input  logic                i_m0_bready,
    // master 1
    input  logic [ADDR_W-1:0]   i_m1_araddr,
    input  logic                i_m1_arvalid,
    output logic                o_m1_arready,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic [1:0]          o_m1_rresp,
    output logic                o_m1_rvalid,
    input  logic                i_m1_rready,
    input  logic [ADDR_W-1:0]   i_m1_awaddr,
    input  logic                i_m1_awvalid,
    output logic                o_m1_awready,
    input  logic [DATA_W-1:0]   i_m1_wdata,
    input  logic [DATA_W/8-1:0] i_m1_wstrb,
    input  logic                i_m1_wvalid,
    output logic                o_m1_wready,
    output logic [1:0]          o_m1_bresp,
    output logic                o_m1_bvalid,
    input  logic                i_m1_bready,
    // shared slave
    output logic [ADDR_W-1:0]   o_s_araddr,
    output logic                o_s_arvalid,
    input  logic                i_s_arready,
    input  logic [DATA_W-1:0]   i_s_rdata,
    input  logic [1:0]          i_s_rresp,
    input  logic                i_s_rvalid,
    output logic                o_s_rready,
    output logic [ADDR_W-1:0]   o_s_awaddr,
    output logic                o_s_awvalid,
    input  logic                i_s_awready,
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    output logic                o_s_wvalid,
    input  logic                i_s_wready,
    input  logic [1:0]          i_s_bresp,
    input  logic                i_s_bvalid,
    output logic                o_s_bready
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state, state_nx;
    logic   gnt, gnt_nx, last, last_nx;
    logic   ar_done, ar_done_nx, aw_done, aw_done_nx, w_done, w_done_nx;

    logic req0, req1, pick;
    logic sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
    logic arready_g, rvalid_g, awready_g, wready_g, bvalid_g, b_open;

    assign req0 = i_m0_arvalid | i_m0_awvalid;
    assign req1 = i_m1_arvalid | i_m1_awvalid;
    // On a tie, round-robin favours whoever was not served last.
    assign pick = (req0 & req1) ? (RR ? ~last : 1'b0) : req1;

    assign sel_arvalid = gnt ? i_m1_arvalid : i_m0_arvalid;
    assign sel_rready  = gnt ? i_m1_rready  : i_m0_rready;
    assign sel_awvalid = gnt ? i_m1_awvalid : i_m0_awvalid;
    assign sel_wvalid  = gnt ? i_m1_wvalid  : i_m0_wvalid;
    assign sel_bready  = gnt ? i_m1_bready  : i_m0_bready;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            last    <= last_nx;
            ar_done <= ar_done_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
        end
    end

    // Next-state logic
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        last_nx    = last;
        ar_done_nx = ar_done;
        aw_done_nx = aw_done;
        w_done_nx  = w_done;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_nx   = pick;
                    state_nx = (pick ? i_m1_arvalid : i_m0_arvalid) ? RD : WR;
                end
            end
            RD: begin
                if (o_s_arvalid & i_s_arready) ar_done_nx = 1'b1;
                if (i_s_rvalid & o_s_rready) begin
                    state_nx   = IDLE;
                    last_nx    = gnt;
                    ar_done_nx = 1'b0;
                end
            end
            WR: begin
                if (o_s_awvalid & i_s_awready) aw_done_nx = 1'b1;
                if (o_s_wvalid & i_s_wready)   w_done_nx  = 1'b1;
                if (i_s_bvalid & o_s_bready) begin
                    state_nx   = IDLE;
                    last_nx    = gnt;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: handshake gating for the granted master only
    always_comb begin
        o_s_arvalid = 1'b0;
        o_s_rready  = 1'b0;
        o_s_awvalid = 1'b0;
        o_s_wvalid  = 1'b0;
        o_s_bready  = 1'b0;
        arready_g   = 1'b0;
        rvalid_g    = 1'b0;
        awready_g   = 1'b0;
        wready_g    = 1'b0;
        bvalid_g    = 1'b0;
        b_open      = 1'b0;
        case (state)
            RD: begin
                o_s_arvalid = sel_arvalid & ~ar_done;
                arready_g   = i_s_arready & ~ar_done;
                o_s_rready  = sel_rready;
                rvalid_g    = i_s_rvalid;
            end
            WR: begin
                o_s_awvalid = sel_awvalid & ~aw_done;
                o_s_wvalid  = sel_wvalid & ~w_done;
                awready_g   = i_s_awready & ~aw_done;
                wready_g    = i_s_wready & ~w_done;
                // B opens once both AW and W are accepted, including in this very cycle.
                b_open      = (aw_done | (o_s_awvalid & i_s_awready)) &
                              (w_done  | (o_s_wvalid  & i_s_wready));
                o_s_bready  = b_open & sel_bready;
                bvalid_g    = b_open & i_s_bvalid;
            end
            default: ;
        endcase
    end

    assign o_m0_arready = arready_g & ~gnt;
    assign o_m1_arready = arready_g &  gnt;
    assign o_m0_rvalid  = rvalid_g  & ~gnt;
    assign o_m1_rvalid  = rvalid_g  &  gnt;
    assign o_m0_awready = awready_g & ~gnt;
    assign o_m1_awready = awready_g &  gnt;
    assign o_m0_wready  = wready_g  & ~gnt;
    assign o_m1_wready  = wready_g  &  gnt;
    assign o_m0_bvalid  = bvalid_g  & ~gnt;
    assign o_m1_bvalid  = bvalid_g  &  gnt;

    assign o_s_araddr = gnt ? i_m1_araddr : i_m0_araddr;
    assign o_s_awaddr = gnt ? i_m1_awaddr : i_m0_awaddr;
    assign o_s_wdata  = gnt ? i_m1_wdata  : i_m0_wdata;
    assign o_s_wstrb  = gnt ? i_m1_wstrb  : i_m0_wstrb;

    assign o_m0_rdata = i_s_rdata;
    assign o_m1_rdata = i_s_rdata;
    assign o_m0_rresp = i_s_rresp;
    assign o_m1_rresp = i_s_rresp;
    assign o_m0_bresp = i_s_bresp;
    assign o_m1_bresp = i_s_bresp;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: a round-robin instance in front of a small SRAM model,
// plus a fixed-priority instance in front of an always-ready slave for the starvation case.
module tb_axi_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // master-side stimulus (index = master number), shared by both instances
    logic [31:0] araddr [2];
    logic [31:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [1:0]  arvalid, rready, awvalid, wvalid, bready;

    // round-robin instance outputs
    wire [1:0]  arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
    wire [31:0] rdata_o [2];
    wire [1:0]  rresp_o [2];
    wire [1:0]  bresp_o [2];
    wire [31:0] s_araddr, s_awaddr, s_wdata;
    wire [3:0]  s_wstrb;
    wire        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

    // fixed-priority instance outputs
    wire [1:0]  arready2, rvalid2, awready2, wready2, bvalid2;
    wire [31:0] rdata2 [2];
    wire [1:0]  rresp2 [2];
    wire [1:0]  bresp2 [2];
    wire [31:0] s2_araddr, s2_awaddr, s2_wdata;
    wire [3:0]  s2_wstrb;
    wire        s2_arvalid, s2_rready, s2_awvalid, s2_wvalid, s2_bready;

    // SRAM slave model state and knobs
    logic [31:0] mem [16];
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp, rd_resp, wr_resp;
    logic        s_rvalid, s_bvalid, rd_pend, have_aw, have_w;
    logic        awready_en, wready_en;
    logic [3:0]  rd_idx, wa_idx;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          rd_lat, rd_cnt;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1'b1)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_m0_araddr(araddr[0]), .i_m0_arvalid(arvalid[0]), .o_m0_arready(arready_o[0]),
        .o_m0_rdata(rdata_o[0]), .o_m0_rresp(rresp_o[0]), .o_m0_rvalid(rvalid_o[0]), .i_m0_rready(rready[0]),
        .i_m0_awaddr(awaddr[0]), .i_m0_awvalid(awvalid[0]), .o_m0_awready(awready_o[0]),
        .i_m0_wdata(wdata[0]), .i_m0_wstrb(wstrb[0]), .i_m0_wvalid(wvalid[0]), .o_m0_wready(wready_o[0]),
        .o_m0_bresp(bresp_o[0]), .o_m0_bvalid(bvalid_o[0]), .i_m0_bready(bready[0]),
        .i_m1_araddr(araddr[1]), .i_m1_arvalid(arvalid[1]), .o_m1_arready(arready_o[1]),
        .o_m1_rdata(rdata_o[1]), .o_m1_rresp(rresp_o[1]), .o_m1_rvalid(rvalid_o[1]), .i_m1_rready(rready[1]),
        .i_m1_awaddr(awaddr[1]), .i_m1_awvalid(awvalid[1]), .o_m1_awready(awready_o[1]),
        .i_m1_wdata(wdata[1]), .i_m1_wstrb(wstrb[1]), .i_m1_wvalid(wvalid[1]), .o_m1_wready(wready_o[1]),
        .o_m1_bresp(bresp_o[1]), .o_m1_bvalid(bvalid_o[1]), .i_m1_bready(bready[1]),
        .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .i_s_arready(1'b1),
        .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
        .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(awready_en),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wvalid(s_wvalid), .i_s_wready(wready_en),
        .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready)
    );

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1'b0)) dut_fp (
        .i_clock(clk), .i_reset(rst),
        .i_m0_araddr(araddr[0]), .i_m0_arvalid(arvalid[0]), .o_m0_arready(arready2[0]),
        .o_m0_rdata(rdata2[0]), .o_m0_rresp(rresp2[0]), .o_m0_rvalid(rvalid2[0]), .i_m0_rready(rready[0]),
        .i_m0_awaddr(awaddr[0]), .i_m0_awvalid(awvalid[0]), .o_m0_awready(awready2[0]),
        .i_m0_wdata(wdata[0]), .i_m0_wstrb(wstrb[0]), .i_m0_wvalid(wvalid[0]), .o_m0_wready(wready2[0]),
        .o_m0_bresp(bresp2[0]), .o_m0_bvalid(bvalid2[0]), .i_m0_bready(bready[0]),
        .i_m1_araddr(araddr[1]), .i_m1_arvalid(arvalid[1]), .o_m1_arready(arready2[1]),
        .o_m1_rdata(rdata2[1]), .o_m1_rresp(rresp2[1]), .o_m1_rvalid(rvalid2[1]), .i_m1_rready(rready[1]),
        .i_m1_awaddr(awaddr[1]), .i_m1_awvalid(awvalid[1]), .o_m1_awready(awready2[1]),
        .i_m1_wdata(wdata[1]), .i_m1_wstrb(wstrb[1]), .i_m1_wvalid(wvalid[1]), .o_m1_wready(wready2[1]),
        .o_m1_bresp(bresp2[1]), .o_m1_bvalid(bvalid2[1]), .i_m1_bready(bready[1]),
        .o_s_araddr(s2_araddr), .o_s_arvalid(s2_arvalid), .i_s_arready(1'b1),
        .i_s_rdata(32'h0), .i_s_rresp(2'b00), .i_s_rvalid(1'b1), .o_s_rready(s2_rready),
        .o_s_awaddr(s2_awaddr), .o_s_awvalid(s2_awvalid), .i_s_awready(1'b1),
        .o_s_wdata(s2_wdata), .o_s_wstrb(s2_wstrb), .o_s_wvalid(s2_wvalid), .i_s_wready(1'b1),
        .i_s_bresp(2'b00), .i_s_bvalid(1'b1), .o_s_bready(s2_bready)
    );

    // SRAM model: read data appears rd_lat cycles after the AR handshake, B one cycle after AW+W.
    always @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 1'b0;
            s_bvalid <= 1'b0;
            rd_pend  <= 1'b0;
            have_aw  <= 1'b0;
            have_w   <= 1'b0;
        end else begin
            if (s_rvalid && s_rready) s_rvalid <= 1'b0;
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            if (s_arvalid) begin
                rd_idx  <= s_araddr[5:2];
                rd_cnt  <= rd_lat;
                rd_pend <= 1'b1;
            end else if (rd_pend) begin
                if (rd_cnt <= 1) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= mem[rd_idx];
                    s_rresp  <= rd_resp;
                    rd_pend  <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
            if (have_aw && have_w) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mem[wa_idx][8*b +: 8] <= wd[8*b +: 8];
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= wr_resp;
            end
            if (s_awvalid && awready_en) begin
                wa_idx  <= s_awaddr[5:2];
                have_aw <= 1'b1;
            end
            if (s_wvalid && wready_en) begin
                wd     <= s_wdata;
                ws     <= s_wstrb;
                have_w <= 1'b1;
            end
        end
    end

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          first_s, aw_n, w_n, done_n, other;
        bit          ok;
    } res_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one transaction on master v.m; cycle indices count negedges from the request.
    task automatic txn(input vec_t v, output res_t r);
        int  m, o;
        bit  a_hs, r_hs, aw_hs, w_hs, b_hs;
        m = v.m;
        o = 1 - m;
        r.data = '0; r.resp = '0; r.ok = 1'b0; r.other = 0;
        r.first_s = -1; r.aw_n = -1; r.w_n = -1; r.done_n = -1;
        if (!v.wr) begin
            rd_lat = v.lat; rd_resp = v.resp;
            araddr[m] = v.addr; arvalid[m] = 1'b1; rready[m] = 1'b1;
        end else begin
            wr_resp = v.resp;
            awaddr[m] = v.addr; wdata[m] = v.data; wstrb[m] = v.strb;
            awvalid[m] = 1'b1; wvalid[m] = 1'b1; bready[m] = 1'b1;
        end
        for (int n = 0; n < 60 && !r.ok; n++) begin
            @(negedge clk);
            if (r.first_s < 0 && (s_arvalid | s_awvalid | s_wvalid)) r.first_s = n;
            if (arready_o[o] | rvalid_o[o] | awready_o[o] | wready_o[o] | bvalid_o[o]) r.other++;
            a_hs  = arvalid[m] & arready_o[m];
            r_hs  = rready[m]  & rvalid_o[m];
            aw_hs = awvalid[m] & awready_o[m];
            w_hs  = wvalid[m]  & wready_o[m];
            b_hs  = bready[m]  & bvalid_o[m];
            if (aw_hs) r.aw_n = n;
            if (w_hs)  r.w_n  = n;
            if (r_hs) begin r.data = rdata_o[m]; r.resp = rresp_o[m]; r.done_n = n; end
            if (b_hs) begin r.resp = bresp_o[m]; r.done_n = n; end
            @(posedge clk);
            #1;
            if (a_hs)  arvalid[m] = 1'b0;
            if (aw_hs) awvalid[m] = 1'b0;
            if (w_hs)  wvalid[m]  = 1'b0;
            if (r_hs) begin rready[m] = 1'b0; r.ok = 1'b1; end
            if (b_hs) begin bready[m] = 1'b0; r.ok = 1'b1; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        vec_t v0, v1;
        res_t r, r0, r1;
        int   cnt_r2, cnt_m1_2, cnt_b1;

        //          m  wr  addr          data          strb lat resp   exp_data      exp_resp
        vecs[0] = '{1, 1, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, 2'b00, 32'h0,        2'b00};
        vecs[1] = '{0, 0, 32'h8000_0000, 32'h0,         4'h0, 3, 2'b00, 32'h1234_5678, 2'b00};
        vecs[2] = '{0, 1, 32'h8000_0004, 32'hA5A5_A5A5, 4'hF, 0, 2'b00, 32'h0,        2'b00};
        vecs[3] = '{1, 1, 32'h8000_0004, 32'h0000_3C00, 4'h2, 0, 2'b00, 32'h0,        2'b00};
        vecs[4] = '{1, 0, 32'h8000_0004, 32'h0,         4'h0, 1, 2'b00, 32'hA5A5_3CA5, 2'b00};
        vecs[5] = '{1, 0, 32'h8000_0000, 32'h0,         4'h0, 2, 2'b10, 32'h1234_5678, 2'b10};
        vecs[6] = '{0, 1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 0, 2'b11, 32'h0,        2'b11};
        vecs[7] = '{0, 0, 32'h8000_0008, 32'h0,         4'h0, 1, 2'b00, 32'hCAFE_F00D, 2'b00};

        for (int i = 0; i < 2; i++) begin
            araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        rd_lat = 1; rd_resp = 2'b00; wr_resp = 2'b00;
        awready_en = 1'b1; wready_en = 1'b1;

        // Reset state: all handshake outputs low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                                arready_o, rvalid_o, awready_o, wready_o, bvalid_o}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of single-master transactions
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i], r);
            check($sformatf("v%0d_done", i), r.ok, 1);
            check($sformatf("v%0d_slave_valid_at_T+1", i), r.first_s, 1);
            check($sformatf("v%0d_other_master_quiet", i), r.other, 0);
            check($sformatf("v%0d_resp", i), r.resp, vecs[i].exp_resp);
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), r.data, vecs[i].exp_data);
        end

        // Simultaneous M0 read and M1 write after reset: M0 wins, M1 follows after one IDLE cycle
        do_reset();
        v0 = '{0, 0, 32'h8000_0000, 32'h0,         4'h0, 1, 2'b00, 32'h1234_5678, 2'b00};
        v1 = '{1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 32'h0,        2'b00};
        fork
            txn(v0, r0);
            txn(v1, r1);
        join
        check("tie_m0_rdata", r0.data, 32'h1234_5678);
        check("tie_m0_r_cycle", r0.done_n, 3);
        check("tie_m1_aw_cycle", r1.aw_n, 5);
        check("tie_m1_bresp", {r1.ok, r1.resp}, 3'b100);
        v0 = '{0, 0, 32'h8000_0010, 32'h0, 4'h0, 2, 2'b00, 32'hDEAD_BEEF, 2'b00};
        txn(v0, r);
        check("tie_mem_updated", r.data, 32'hDEAD_BEEF);

        // M1 write with W accepted two cycles before AW: single B only after both
        awready_en = 1'b0;
        v1 = '{1, 1, 32'h8000_0014, 32'h0BAD_F00D, 4'hF, 0, 2'b00, 32'h0, 2'b00};
        fork
            txn(v1, r);
            begin
                repeat (3) @(posedge clk);
                #1 awready_en = 1'b1;
            end
        join
        check("wfirst_w_cycle", r.w_n, 1);
        check("wfirst_aw_cycle", r.aw_n, 3);
        check("wfirst_b_cycle", r.done_n, 5);
        check("wfirst_bresp", {r.ok, r.resp}, 3'b100);
        check("wfirst_m0_quiet", r.other, 0);

        // Reset during the RD wait, then a fresh read
        rd_lat = 8;
        araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1; rready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 arvalid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrd_reset_outputs", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                                      arready_o, rvalid_o, awready_o, wready_o, bvalid_o}, 0);
        @(posedge clk);
        #1 rst = 1'b0; rready[0] = 1'b0;
        v0 = '{0, 0, 32'h8000_0000, 32'h0, 4'h0, 2, 2'b00, 32'h1234_5678, 2'b00};
        txn(v0, r);
        check("after_reset_done", r.ok, 1);
        check("after_reset_latency", r.first_s, 1);
        check("after_reset_rdata", r.data, 32'h1234_5678);

        // M0 reads continuously while M1 wants to write: fixed priority starves M1, round-robin does not
        do_reset();
        rd_lat = 1;
        araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1; rready[0] = 1'b1;
        awaddr[1] = 32'h8000_0020; wdata[1] = 32'h5555_AAAA; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b1;
        cnt_r2 = 0; cnt_m1_2 = 0; cnt_b1 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rvalid2[0]) cnt_r2++;
            if (s2_awvalid | s2_wvalid | awready2[1] | wready2[1] | bvalid2[1]) cnt_m1_2++;
            if (bvalid_o[1]) cnt_b1++;
        end
        check("fp_m0_reads", cnt_r2, 15);
        check("fp_m1_starved", cnt_m1_2, 0);
        check("rr_m1_served", cnt_b1 > 0, 1);
        @(posedge clk);
        #1 arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
